// File: rtl/fifo_rr_write_arbiter.sv
// Purpose : shares one FIFO write port between NREQ packet producers, granting
//           whole packets round-robin (split after MAXLEN beats).
// Latency : 1 IDLE bubble per grant, then data passes combinationally to the FIFO.
// Backpr. : fifo_full drops the owner's ready and wen; the lock is held until full clears.
// Ports   : req_valid/req_last/req_data in, req_ready out (per requester);
//           fifo_wdata/fifo_wen out, fifo_full in; grant_id = owner, busy = locked.
module fifo_rr_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 16,
    parameter int IDXW   = 2,
    parameter int MAXLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      fifo_wdata,
    output logic                  fifo_wen,
    input  logic                  fifo_full,
    output logic [IDXW-1:0]       grant_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [6:0]      beat_cnt_q, beat_cnt_d;

    logic             own_valid;
    logic             own_last;
    logic [WIDTH-1:0] own_data;
    logic [IDXW-1:0]  winner;
    logic [IDXW-1:0]  owner_next;
    logic             beat;
    logic             release_pkt;

    // Select the current owner's request lane.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDXW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                winner = IDXW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign owner_next  = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + 1'b1;
    assign beat        = (state_q == LOCK) && own_valid && !fifo_full;
    // Release on the packet's last word, or when this beat fills the MAXLEN budget.
    assign release_pkt = beat && (own_last || ((beat_cnt_q + 7'd1) == 7'(MAXLEN)));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 7'd1;
                end
                if (release_pkt) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Ready is offered to the owner whenever the FIFO has room, even if it is
    // not presenting a word this cycle.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state_q == LOCK) && !fifo_full && (owner_q == IDXW'(i));
        end
    end

    assign fifo_wen   = beat;
    assign fifo_wdata = (state_q == LOCK) ? own_data : '0;
    assign grant_id   = owner_q;
    assign busy       = (state_q == LOCK);

endmodule
